fir_filter_n: RTL and testbench
===============================

# fir_filter_n

Parametrised direct-form N-tap FIR filter on signed fixed-point Q(WI.WF) samples. It is the successor to the three-tap filter.
- Tap count and word format are parameters.
- Coefficients load through a counted shift-in sequence guarded by a small state machine.
- Samples and results use valid/ready flow control.
- Accumulation is full precision, and the output is rounded and saturated with a sticky overflow flag.
- It sits between the sample source and downstream fixed-point datapath, replacing the fixed three-tap block.

## Interface
Parameters:
- TAPS, 3, number of taps; ≥2.
- WI, 2, integer bits of x, h, y (sign included).
- WF, 6, fraction bits of x, h, y; WL = WI+WF.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- coef_wr  in  1  coefficient write strobe.
- coef_in  in  WL  coefficient word, signed Q(WI.WF).
- x_valid  in  1  sample present.
- x_in  in  WL  sample, signed Q(WI.WF).
- x_ready  out  1  high only in RUN.
- y_valid  out  1  result valid, one-cycle pulse per accepted sample.
- y_out  out  WL  result, signed Q(WI.WF).
- ovf  out  1  sticky saturation flag.
- coef_loaded  out  1  high in RUN.

## Operation
States:
- LOAD: the reset state. Coefficients are incomplete; x_ready=0 and x_valid is ignored.
- RUN: sample processing.

Coefficient load:
- Each coef_wr cycle does h[0]<=coef_in and h[k]<=h[k-1], and increments a load counter 0..TAPS-1.
- The first word written ends in h[TAPS-1].
- When the TAPS-th write completes, the state goes to RUN and the counter clears.
- coef_wr while in RUN:
  - Returns the state to LOAD.
  - That write counts as write 1 of a new sequence.
  - The delay line is cleared to 0 and ovf is cleared.

Sample accept:
- A sample is accepted when x_valid && x_ready && !coef_wr.
- On accept, x_dly[0]<=x_in and x_dly[k]<=x_dly[k-1].
- If coef_wr and x_valid are both high in RUN, coef_wr wins and the sample is dropped.

Arithmetic:
- Products are full 2·WL bits.
- The accumulator is 2·WL+clog2(TAPS) bits, giving a Q(2WI+clog2(TAPS)).(2WF) sum.
- Rounding: add 2^(WF-1), then arithmetic shift right by WF (round half up).
- Saturation: clamp to [−2^(WL−1), 2^(WL−1)−1]. Any clamp sets ovf, which stays set until reset or coefficient reload.

Reset values: state=LOAD; h, x_dly and the load counter all 0; y_out=0, y_valid=0, ovf=0, x_ready=0, coef_loaded=0.

## Timing
- An accept at the edge ending cycle t updates the delay line.
- The sum of products over the updated line is registered at the next edge, so y_valid=1 and y_out are visible in cycle t+2. Latency is 2 and throughput is 1 sample/cycle.
- A coef_wr in cycle t+1 does not affect the result of a sample accepted in t. That result is still emitted in t+2, computed with the old coefficients.
- x_ready and coef_loaded change on the edge that changes state. The first accept is possible in the cycle after the TAPS-th write.
- y_valid is registered, with no combinational path from inputs.
- reset_n low mid-operation forces all reset values immediately, including dropping an in-flight y_valid. Deassertion is synchronised externally.

## Structure
- Package fir_pkg holds:
  - State encoding (LOAD, RUN).
  - Width constants/functions: WL, product width, accumulator width, clog2.
  - Saturate/round function.
- Sub-module fir_tap_mult: one signed WL×WL full-precision multiplier, instantiated TAPS times via generate.
- The adder tree, round, saturate, state machine and delay line stay in the top level.

## Test plan
All scenarios use TAPS=3, Q2.6; the load sequence writes 0x1A, 0x33, 0xEB (h=[−21,51,26]/64).
- Load and run: write the three coefficients, then x=0x0D, 0xE6, 0x26, 0xCD on consecutive cycles → y_out = 0xFC, 0x13, 0xE4, 0x24 in cycles t+2..t+5 with y_valid high. coef_loaded=1 after the third write.
- Positive saturation: h all 0x7F, x=0x7F for 3 samples → third y_out=0x7F, ovf=1 and stays 1 across later in-range samples.
- Negative saturation: h all 0x7F, x=0x80 for 3 samples → y_out=0x80, ovf=1.
- LOAD gating: x_valid high during and after only two coef writes → x_ready=0, no y_valid. After the third write, the next sample is accepted.
- Collision and reload: in RUN, coef_wr and x_valid high in the same cycle → sample dropped, state LOAD, x_ready=0, ovf cleared. A result already in flight still appears once.
- Reset mid-stream: reset_n low in the cycle before an expected y_valid → y_valid=0, y_out=0, state LOAD, and all coefficients/samples are zero after release.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the N-tap FIR filter: state encoding, width helpers
// and the round/saturate step applied to the full-precision sum.
package fir_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } fir_state_t;

    // Working width of the round/saturate helper; any accumulator up to this
    // width is sign-extended into it before rounding.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic             ovf;
        logic [SAT_W-1:0] value;
    } sat_result_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic int word_width(input int wi, input int wf);
        return wi + wf;
    endfunction

    function automatic int prod_width(input int wl);
        return 2 * wl;
    endfunction

    // Products plus enough guard bits that summing all taps cannot wrap.
    function automatic int acc_width(input int wl, input int taps);
        return 2 * wl + clog2(taps);
    endfunction

    // Round half up by adding 2^(wf-1) and shifting right by wf, then clamp
    // into the signed wl-bit range. The result is sign-extended to SAT_W bits.
    function automatic sat_result_t round_sat(input logic signed [SAT_W-1:0] acc,
                                              input int wl, input int wf);
        logic signed [SAT_W-1:0] rnd;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_result_t             r;
        rnd   = (acc + (64'sd1 <<< (wf - 1))) >>> wf;
        max_v = (64'sd1 <<< (wl - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (wl - 1));
        r.ovf   = 1'b0;
        r.value = rnd;
        if (rnd > max_v) begin
            r.value = max_v;
            r.ovf   = 1'b1;
        end else if (rnd < min_v) begin
            r.value = min_v;
            r.ovf   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_tap_mult.sv
// One signed WL x WL multiplier producing the full 2*WL-bit product.
module fir_tap_mult #(
    parameter int WL = 8
) (
    input  logic signed [WL-1:0]   a,
    input  logic signed [WL-1:0]   b,
    output logic signed [2*WL-1:0] p
);

    logic signed [2*WL-1:0] a_ext;
    logic signed [2*WL-1:0] b_ext;

    // Sign-extend both operands so the product is exact in 2*WL bits.
    always_comb begin
        a_ext = {{WL{a[WL-1]}}, a};
        b_ext = {{WL{b[WL-1]}}, b};
        p     = a_ext * b_ext;
    end

endmodule

// File: rtl/fir_filter_n.sv
// Direct-form N-tap FIR filter with counted coefficient load, valid/ready
// sample flow, full-precision accumulation and rounded, saturated output.
module fir_filter_n
    import fir_pkg::*;
#(
    parameter int TAPS = 3,
    parameter int WI   = 2,
    parameter int WF   = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 coef_wr,
    input  logic [WI+WF-1:0]     coef_in,
    input  logic                 x_valid,
    input  logic [WI+WF-1:0]     x_in,
    output logic                 x_ready,
    output logic                 y_valid,
    output logic [WI+WF-1:0]     y_out,
    output logic                 ovf,
    output logic                 coef_loaded
);

    localparam int WL = word_width(WI, WF);
    localparam int PW = prod_width(WL);
    localparam int AW = acc_width(WL, TAPS);
    localparam int CW = clog2(TAPS);

    fir_state_t            state;
    fir_state_t            next_state;
    logic [CW-1:0]         load_cnt;
    logic signed [WL-1:0]  h     [TAPS];
    logic signed [WL-1:0]  x_dly [TAPS];
    logic signed [PW-1:0]  prod  [TAPS];
    logic signed [AW-1:0]  sum;
    logic [SAT_W-1:0]      acc_ext;
    sat_result_t           sat;
    logic [WL-1:0]         y_next;
    logic                  y_clamped;
    logic                  accept;
    logic                  reload;
    logic                  pend;

    // One multiplier per tap, pairing each coefficient with its delayed sample.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        fir_tap_mult #(.WL(WL)) u_mult (
            .a (h[k]),
            .b (x_dly[k]),
            .p (prod[k])
        );
    end

    // Next state and state-decoded flags; a write in RUN restarts the load.
    always_comb begin
        next_state  = state;
        x_ready     = 1'b0;
        coef_loaded = 1'b0;
        case (state)
            LOAD: begin
                if (coef_wr && (load_cnt == CW'(TAPS - 1))) next_state = RUN;
            end
            RUN: begin
                x_ready     = 1'b1;
                coef_loaded = 1'b1;
                if (coef_wr) next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
        accept = x_valid && x_ready && !coef_wr;
        reload = coef_wr && (state == RUN);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LOAD;
        else          state <= next_state;
    end

    // Coefficient shift register and load counter; a reload counts as write 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt <= '0;
            for (int k = 0; k < TAPS; k++) h[k] <= '0;
        end else if (coef_wr) begin
            h[0] <= coef_in;
            for (int k = 1; k < TAPS; k++) h[k] <= h[k-1];
            if (reload)                            load_cnt <= CW'(1);
            else if (load_cnt == CW'(TAPS - 1))    load_cnt <= '0;
            else                                   load_cnt <= load_cnt + CW'(1);
        end
    end

    // Sample delay line, cleared when a new coefficient set starts in RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) x_dly[k] <= '0;
        end else if (reload) begin
            for (int k = 0; k < TAPS; k++) x_dly[k] <= '0;
        end else if (accept) begin
            x_dly[0] <= x_in;
            for (int k = 1; k < TAPS; k++) x_dly[k] <= x_dly[k-1];
        end
    end

    // Full-precision sum of products, then round and saturate to WL bits.
    // The clamp check on the upper bits guards against the saturation bounds
    // and the output width ever disagreeing.
    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + {{(AW-PW){prod[k][PW-1]}}, prod[k]};
        end
        acc_ext   = {{(SAT_W-AW){sum[AW-1]}}, sum};
        sat       = round_sat(acc_ext, WL, WF);
        y_next    = sat.value[WL-1:0];
        y_clamped = sat.ovf |
                    (|(sat.value[SAT_W-1:WL] ^ {(SAT_W-WL){sat.value[WL-1]}}));
    end

    // Output stage: the result for an accepted sample is registered one edge
    // after the delay line moves, using the coefficients present at that time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend    <= 1'b0;
            y_valid <= 1'b0;
            y_out   <= '0;
            ovf     <= 1'b0;
        end else begin
            pend    <= accept;
            y_valid <= pend;
            if (pend) y_out <= y_next;
            if (reload)                 ovf <= 1'b0;
            else if (pend && y_clamped) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_filter_n.sv
// Directed bench for fir_filter_n (TAPS=3, Q2.6) with hand-computed results.
module tb_fir_filter_n;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       coef_wr;
    logic [7:0] coef_in;
    logic       x_valid;
    logic [7:0] x_in;
    logic       x_ready;
    logic       y_valid;
    logic [7:0] y_out;
    logic       ovf;
    logic       coef_loaded;

    int checks = 0;
    int errors = 0;

    // h = [-21, 51, 26]/64 after writing 0x1A, 0x33, 0xEB
    logic [7:0] runX [4] = '{8'h0D, 8'hE6, 8'h26, 8'hCD};
    logic [7:0] runY [4] = '{8'hFC, 8'h13, 8'hE4, 8'h24};
    // h all 0x7F
    logic [7:0] posX [6] = '{8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00};
    logic [7:0] posY [6] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00};
    logic [7:0] negX [4] = '{8'h01, 8'h80, 8'h80, 8'h80};
    logic [7:0] negY [4] = '{8'h02, 8'h80, 8'h80, 8'h80};
    logic       negO [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    fir_filter_n #(.TAPS(3), .WI(2), .WF(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .coef_wr     (coef_wr),
        .coef_in     (coef_in),
        .x_valid     (x_valid),
        .x_in        (x_in),
        .x_ready     (x_ready),
        .y_valid     (y_valid),
        .y_out       (y_out),
        .ovf         (ovf),
        .coef_loaded (coef_loaded)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic cw, input logic [7:0] cin,
                                 input logic xv, input logic [7:0] xin);
        coef_wr = cw;
        coef_in = cin;
        x_valid = xv;
        x_in    = xin;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loadCoefs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        applyStimulus(1'b1, a, 1'b0, 8'h00); nextCycle();
        applyStimulus(1'b1, b, 1'b0, 8'h00); nextCycle();
        applyStimulus(1'b1, c, 1'b0, 8'h00); nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (2) nextCycle();
        reset_n = 1'b1;
        nextCycle();
    endtask

    initial begin
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        #2 reset_n = 1'b0;
        repeat (2) nextCycle();
        checkOutput("rst_y_valid", 32'(y_valid), 32'h0);
        checkOutput("rst_y_out", 32'(y_out), 32'h0);
        checkOutput("rst_ovf", 32'(ovf), 32'h0);
        checkOutput("rst_x_ready", 32'(x_ready), 32'h0);
        checkOutput("rst_coef_loaded", 32'(coef_loaded), 32'h0);
        reset_n = 1'b1;
        nextCycle();

        // LOAD gating: samples offered during an incomplete load are ignored
        $display("[TB] load gating and run");
        applyStimulus(1'b1, 8'h1A, 1'b1, 8'h55);
        checkOutput("gate_rdy_w1", 32'(x_ready), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 8'h33, 1'b1, 8'h55);
        checkOutput("gate_rdy_w2", 32'(x_ready), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h55);
        checkOutput("gate_rdy_gap", 32'(x_ready), 32'h0);
        checkOutput("gate_loaded_gap", 32'(coef_loaded), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 8'hEB, 1'b1, 8'h55);
        checkOutput("gate_rdy_w3", 32'(x_ready), 32'h0);
        checkOutput("gate_yv_w3", 32'(y_valid), 32'h0);
        nextCycle();
        checkOutput("run_loaded", 32'(coef_loaded), 32'h1);
        checkOutput("run_ready", 32'(x_ready), 32'h1);
        checkOutput("run_yv_first", 32'(y_valid), 32'h0);

        for (int i = 0; i < 6; i++) begin
            if (i < 4) applyStimulus(1'b0, 8'h00, 1'b1, runX[i]);
            else       applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
            if (i == 1) checkOutput("run_yv_lat", 32'(y_valid), 32'h0);
            if (i >= 2) begin
                checkOutput($sformatf("run_yv_%0d", i-2), 32'(y_valid), 32'h1);
                checkOutput($sformatf("run_y_%0d", i-2), 32'(y_out), 32'(runY[i-2]));
            end
            nextCycle();
        end
        checkOutput("run_yv_end", 32'(y_valid), 32'h0);

        // Positive saturation with sticky overflow
        $display("[TB] positive saturation");
        doReset();
        loadCoefs(8'h7F, 8'h7F, 8'h7F);
        for (int i = 0; i < 8; i++) begin
            if (i < 6) applyStimulus(1'b0, 8'h00, 1'b1, posX[i]);
            else       applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
            if (i >= 2) begin
                checkOutput($sformatf("pos_yv_%0d", i-2), 32'(y_valid), 32'h1);
                checkOutput($sformatf("pos_y_%0d", i-2), 32'(y_out), 32'(posY[i-2]));
                checkOutput($sformatf("pos_ovf_%0d", i-2), 32'(ovf), 32'h1);
            end
            nextCycle();
        end

        // Collision: coef_wr beats x_valid, in-flight result still emerges
        $display("[TB] collision and reload");
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h01);
        nextCycle();
        applyStimulus(1'b1, 8'h7F, 1'b1, 8'h7F);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h7F);
        checkOutput("col_yv", 32'(y_valid), 32'h1);
        checkOutput("col_y", 32'(y_out), 32'h02);
        checkOutput("col_ready", 32'(x_ready), 32'h0);
        checkOutput("col_loaded", 32'(coef_loaded), 32'h0);
        checkOutput("col_ovf", 32'(ovf), 32'h0);
        nextCycle();
        checkOutput("col_yv_drop", 32'(y_valid), 32'h0);
        applyStimulus(1'b1, 8'h7F, 1'b0, 8'h00); nextCycle();
        applyStimulus(1'b1, 8'h7F, 1'b0, 8'h00); nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("reload_loaded", 32'(coef_loaded), 32'h1);
        checkOutput("reload_yv", 32'(y_valid), 32'h0);

        // Negative saturation after reload (delay line was cleared)
        $display("[TB] negative saturation");
        for (int i = 0; i < 6; i++) begin
            if (i < 4) applyStimulus(1'b0, 8'h00, 1'b1, negX[i]);
            else       applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
            if (i >= 2) begin
                checkOutput($sformatf("neg_yv_%0d", i-2), 32'(y_valid), 32'h1);
                checkOutput($sformatf("neg_y_%0d", i-2), 32'(y_out), 32'(negY[i-2]));
                checkOutput($sformatf("neg_ovf_%0d", i-2), 32'(ovf), 32'(negO[i-2]));
            end
            nextCycle();
        end

        // Reset mid-stream drops the in-flight result
        $display("[TB] reset mid-stream");
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h0D);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_yv", 32'(y_valid), 32'h0);
        checkOutput("mid_rst_y", 32'(y_out), 32'h0);
        checkOutput("mid_rst_ovf", 32'(ovf), 32'h0);
        checkOutput("mid_rst_ready", 32'(x_ready), 32'h0);
        checkOutput("mid_rst_loaded", 32'(coef_loaded), 32'h0);
        nextCycle();
        checkOutput("mid_rst_yv_t2", 32'(y_valid), 32'h0);
        reset_n = 1'b1;
        nextCycle();
        loadCoefs(8'h40, 8'h40, 8'h40);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h40);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        nextCycle();
        checkOutput("post_rst_yv", 32'(y_valid), 32'h1);
        checkOutput("post_rst_y", 32'(y_out), 32'h40);
        checkOutput("post_rst_ovf", 32'(ovf), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
